cdb_arbiter: RTL and testbench

//  - Parametrised common-data-bus arbiter for the Tomasulo core: N_FU result channels, one broadcast per cycle.
//  - Each FU pulses finish with result/tag/pc. The arbiter latches them into a per-channel holding slot and back-pressures that FU via fu_hold.
//  - It drives a registered CDB (valid/tag/data/pc) consumed by Regs (RAT) and all RS instances. Also provides flush.

---
 rtl/cdb_arbiter.sv | 157 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-FU holding slots, one registered broadcast per cycle.
// Optional same-cycle bypass of finishing results when CDB_BYPASS_EN is defined.
module cdb_arbiter #(
    parameter int unsigned N_FU     = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned ARB_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic [N_FU-1:0]          fu_finish_i,
    input  logic [N_FU*DATA_W-1:0]   fu_data_i,
    input  logic [N_FU*TAG_W-1:0]    fu_tag_i,
    input  logic [N_FU*DATA_W-1:0]   fu_pc_i,
    output logic [N_FU-1:0]          fu_hold_o,
    output logic                     cdb_valid_o,
    output logic [TAG_W-1:0]         cdb_tag_o,
    output logic [DATA_W-1:0]        cdb_data_o,
    output logic [DATA_W-1:0]        cdb_pc_o,
    output logic [N_FU-1:0]          grant_oh_o
);

    localparam int unsigned PtrW = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]   slot_valid_q;
    logic [DATA_W-1:0] slot_data_q [N_FU];
    logic [TAG_W-1:0]  slot_tag_q  [N_FU];
    logic [DATA_W-1:0] slot_pc_q   [N_FU];
    logic [PtrW-1:0]   ptr_q;
    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [DATA_W-1:0] cdb_pc_q;
    logic [N_FU-1:0]   grant_q;

    logic [N_FU-1:0]   req;
    logic [N_FU-1:0]   bypass_req;
    logic [N_FU-1:0]   win_oh;
    logic              win_found;
    logic [PtrW-1:0]   win_idx;
    logic [N_FU-1:0]   slot_set;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic [DATA_W-1:0] win_pc;
    int unsigned       rr_idx;

`ifdef CDB_BYPASS_EN
    assign bypass_req = fu_finish_i & ~slot_valid_q;
`else
    assign bypass_req = '0;
`endif

    assign req = slot_valid_q | bypass_req;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < int'(N_FU); i++) begin
                if (req[i] && !win_found) begin
                    win_found = 1'b1;
                    win_idx   = PtrW'(i);
                end
            end
        end else begin
            // Search starts just after the last winner and wraps around.
            for (int k = 1; k <= int'(N_FU); k++) begin
                rr_idx = (int'(ptr_q) + k) % N_FU;
                if (req[rr_idx] && !win_found) begin
                    win_found = 1'b1;
                    win_idx   = PtrW'(rr_idx);
                end
            end
        end
        win_oh = win_found ? (N_FU'(1) << win_idx) : '0;
    end

    always_comb begin
        win_tag  = '0;
        win_data = '0;
        win_pc   = '0;
        for (int i = 0; i < int'(N_FU); i++) begin
            if (win_oh[i]) begin
                win_tag  = slot_tag_q[i];
                win_data = slot_data_q[i];
                win_pc   = slot_pc_q[i];
`ifdef CDB_BYPASS_EN
                if (!slot_valid_q[i]) begin
                    win_tag  = fu_tag_i[i*TAG_W +: TAG_W];
                    win_data = fu_data_i[i*DATA_W +: DATA_W];
                    win_pc   = fu_pc_i[i*DATA_W +: DATA_W];
                end
`endif
            end
        end
    end

    // A bypass winner goes straight to the bus and never occupies its slot.
    assign slot_set = fu_finish_i & ~slot_valid_q & ~win_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= '0;
            for (int i = 0; i < int'(N_FU); i++) begin
                slot_data_q[i] <= '0;
                slot_tag_q[i]  <= '0;
                slot_pc_q[i]   <= '0;
            end
            ptr_q       <= PtrW'(N_FU - 1);
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_pc_q    <= '0;
            grant_q     <= '0;
        end else if (flush_i) begin
            slot_valid_q <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_pc_q     <= '0;
            grant_q      <= '0;
        end else begin
            for (int i = 0; i < int'(N_FU); i++) begin
                if (win_oh[i]) begin
                    slot_valid_q[i] <= 1'b0;
                end else if (slot_set[i]) begin
                    slot_valid_q[i] <= 1'b1;
                    slot_data_q[i]  <= fu_data_i[i*DATA_W +: DATA_W];
                    slot_tag_q[i]   <= fu_tag_i[i*TAG_W +: TAG_W];
                    slot_pc_q[i]    <= fu_pc_i[i*DATA_W +: DATA_W];
                end
            end
            cdb_valid_q <= win_found;
            cdb_tag_q   <= win_tag;
            cdb_data_q  <= win_data;
            cdb_pc_q    <= win_pc;
            grant_q     <= win_oh;
            if (win_found) begin
                ptr_q <= win_idx;
            end
        end
    end

    assign fu_hold_o   = slot_valid_q;
    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_pc_o    = cdb_pc_q;
    assign grant_oh_o  = grant_q;

    finish_on_held_a : assert property (@(posedge clk) disable iff (!rst_n)
        (fu_finish_i & slot_valid_q) == '0)
        else $warning("protocol violation: fu_finish on an occupied slot, new result dropped");

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: one round-robin and one fixed-priority instance share stimulus.
module tb_cdb_arbiter;
    localparam int N  = 5;
    localparam int DW = 32;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [N-1:0]    fin = '0;
    logic [N*DW-1:0] data = '0;
    logic [N*DW-1:0] pc = '0;
    logic [N*TW-1:0] tag = '0;

    logic [N-1:0]  r_hold, r_gnt, f_hold, f_gnt;
    logic          r_valid, f_valid;
    logic [TW-1:0] r_tag, f_tag;
    logic [DW-1:0] r_data, r_pc, f_data, f_pc;

    cdb_arbiter #(.N_FU(N), .DATA_W(DW), .TAG_W(TW), .ARB_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .fu_finish_i(fin), .fu_data_i(data),
        .fu_tag_i(tag), .fu_pc_i(pc), .fu_hold_o(r_hold), .cdb_valid_o(r_valid),
        .cdb_tag_o(r_tag), .cdb_data_o(r_data), .cdb_pc_o(r_pc), .grant_oh_o(r_gnt)
    );

    cdb_arbiter #(.N_FU(N), .DATA_W(DW), .TAG_W(TW), .ARB_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .fu_finish_i(fin), .fu_data_i(data),
        .fu_tag_i(tag), .fu_pc_i(pc), .fu_hold_o(f_hold), .cdb_valid_o(f_valid),
        .cdb_tag_o(f_tag), .cdb_data_o(f_data), .cdb_pc_o(f_pc), .grant_oh_o(f_gnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         fl;
        logic [N-1:0] fn;
        logic [7:0]   tb;
        logic         rv;
        logic [7:0]   rtag;
        logic [N-1:0] rgnt;
        logic [N-1:0] rhold;
        logic [7:0]   ftag;
        logic [N-1:0] fgnt;
        logic [N-1:0] fhold;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Channel i gets tag tb+i; data and pc are derived from that tag.
    task automatic drive(input logic fl, input logic [N-1:0] f, input logic [7:0] tb);
        logic [7:0] t;
        flush = fl;
        fin   = f;
        for (int i = 0; i < N; i++) begin
            t = 8'(tb + 8'(i));
            tag[i*TW +: TW]  = t;
            data[i*DW +: DW] = 32'hA500_0000 | 32'(t);
            pc[i*DW +: DW]   = 32'(t) << 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ed;
        vecs[0]  = '{1'b0, 5'b11111, 8'h01, 1'b0, 8'h00, 5'b00000, 5'b11111, 8'h00, 5'b00000, 5'b11111};
        vecs[1]  = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h01, 5'b00001, 5'b11110, 8'h01, 5'b00001, 5'b11110};
        vecs[2]  = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h02, 5'b00010, 5'b11100, 8'h02, 5'b00010, 5'b11100};
        vecs[3]  = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h03, 5'b00100, 5'b11000, 8'h03, 5'b00100, 5'b11000};
        vecs[4]  = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h04, 5'b01000, 5'b10000, 8'h04, 5'b01000, 5'b10000};
        vecs[5]  = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h05, 5'b10000, 5'b00000, 8'h05, 5'b10000, 5'b00000};
        vecs[6]  = '{1'b0, 5'b00000, 8'h00, 1'b0, 8'h00, 5'b00000, 5'b00000, 8'h00, 5'b00000, 5'b00000};
        vecs[7]  = '{1'b0, 5'b00001, 8'h10, 1'b0, 8'h00, 5'b00000, 5'b00001, 8'h00, 5'b00000, 5'b00001};
        vecs[8]  = '{1'b0, 5'b00010, 8'h20, 1'b1, 8'h10, 5'b00001, 5'b00010, 8'h10, 5'b00001, 5'b00010};
        vecs[9]  = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h21, 5'b00010, 5'b00000, 8'h21, 5'b00010, 5'b00000};
        vecs[10] = '{1'b0, 5'b00000, 8'h00, 1'b0, 8'h00, 5'b00000, 5'b00000, 8'h00, 5'b00000, 5'b00000};
        vecs[11] = '{1'b0, 5'b01001, 8'h30, 1'b0, 8'h00, 5'b00000, 5'b01001, 8'h00, 5'b00000, 5'b01001};
        vecs[12] = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h33, 5'b01000, 5'b00001, 8'h30, 5'b00001, 5'b01000};
        vecs[13] = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h30, 5'b00001, 5'b00000, 8'h33, 5'b01000, 5'b00000};
        vecs[14] = '{1'b0, 5'b01001, 8'h40, 1'b0, 8'h00, 5'b00000, 5'b01001, 8'h00, 5'b00000, 5'b01001};
        vecs[15] = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h43, 5'b01000, 5'b00001, 8'h40, 5'b00001, 5'b01000};
        vecs[16] = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h40, 5'b00001, 5'b00000, 8'h43, 5'b01000, 5'b00000};
        vecs[17] = '{1'b0, 5'b10010, 8'h50, 1'b0, 8'h00, 5'b00000, 5'b10010, 8'h00, 5'b00000, 5'b10010};
        vecs[18] = '{1'b1, 5'b00100, 8'h50, 1'b0, 8'h00, 5'b00000, 5'b00000, 8'h00, 5'b00000, 5'b00000};
        vecs[19] = '{1'b0, 5'b00000, 8'h00, 1'b0, 8'h00, 5'b00000, 5'b00000, 8'h00, 5'b00000, 5'b00000};
        vecs[20] = '{1'b0, 5'b00000, 8'h00, 1'b0, 8'h00, 5'b00000, 5'b00000, 8'h00, 5'b00000, 5'b00000};
        vecs[21] = '{1'b0, 5'b00001, 8'h60, 1'b0, 8'h00, 5'b00000, 5'b00001, 8'h00, 5'b00000, 5'b00001};
        vecs[22] = '{1'b0, 5'b00000, 8'h00, 1'b1, 8'h60, 5'b00001, 5'b00000, 8'h60, 5'b00001, 5'b00000};
        vecs[23] = '{1'b1, 5'b00000, 8'h00, 1'b0, 8'h00, 5'b00000, 5'b00000, 8'h00, 5'b00000, 5'b00000};

        // Reset with every channel finishing: everything stays zero.
        drive(1'b0, 5'b11111, 8'h01);
        tick();
        chk("rst valid", 32'(r_valid), 32'd0);
        chk("rst hold", 32'(r_hold), 32'd0);
        chk("rst grant", 32'(r_gnt), 32'd0);
        chk("rst tag", 32'(r_tag), 32'd0);
        chk("rst data", r_data, 32'd0);
        drive(1'b0, 5'b00000, 8'h00);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("idle%0d valid", c), 32'(r_valid), 32'd0);
            chk($sformatf("idle%0d hold", c), 32'(r_hold), 32'd0);
        end

        // Single result on ch2: two-edge latency.
        drive(1'b0, 5'b00100, 8'h00);
        tag[2*TW +: TW]  = 8'h21;
        data[2*DW +: DW] = 32'hDEAD_BEEF;
        pc[2*DW +: DW]   = 32'h40;
        tick();
        fin = '0;
        chk("single hold", 32'(r_hold), 32'h4);
        chk("single early valid", 32'(r_valid), 32'd0);
        tick();
        chk("single valid", 32'(r_valid), 32'd1);
        chk("single tag", 32'(r_tag), 32'h21);
        chk("single data", r_data, 32'hDEAD_BEEF);
        chk("single pc", r_pc, 32'h40);
        chk("single grant", 32'(r_gnt), 32'h4);
        chk("single fp grant", 32'(f_gnt), 32'h4);
        chk("single hold clr", 32'(r_hold), 32'd0);
        tick();
        chk("single after valid", 32'(r_valid), 32'd0);
        chk("single after data", r_data, 32'd0);

        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].fl, vecs[i].fn, vecs[i].tb);
            tick();
            ed = vecs[i].rv ? (32'hA500_0000 | 32'(vecs[i].rtag)) : 32'd0;
            chk($sformatf("v%0d rr valid", i), 32'(r_valid), 32'(vecs[i].rv));
            chk($sformatf("v%0d rr tag", i), 32'(r_tag), 32'(vecs[i].rtag));
            chk($sformatf("v%0d rr data", i), r_data, ed);
            chk($sformatf("v%0d rr pc", i), r_pc, vecs[i].rv ? (32'(vecs[i].rtag) << 2) : 32'd0);
            chk($sformatf("v%0d rr grant", i), 32'(r_gnt), 32'(vecs[i].rgnt));
            chk($sformatf("v%0d rr hold", i), 32'(r_hold), 32'(vecs[i].rhold));
            chk($sformatf("v%0d fp valid", i), 32'(f_valid), 32'(vecs[i].fgnt != '0));
            chk($sformatf("v%0d fp tag", i), 32'(f_tag), 32'(vecs[i].ftag));
            chk($sformatf("v%0d fp grant", i), 32'(f_gnt), 32'(vecs[i].fgnt));
            chk($sformatf("v%0d fp hold", i), 32'(f_hold), 32'(vecs[i].fhold));
        end

        // Finish on an occupied slot: original result wins, new one is dropped.
        drive(1'b0, 5'b00001, 8'h70);
        data[0 +: DW] = 32'h1111_1111;
        tick();
        chk("viol hold", 32'(r_hold), 32'h1);
        data[0 +: DW] = 32'h2222_2222;
        tick();
        fin = '0;
        chk("viol valid", 32'(r_valid), 32'd1);
        chk("viol data", r_data, 32'h1111_1111);
        chk("viol hold drop", 32'(r_hold), 32'd0);

        // Asynchronous reset while broadcasting.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async valid", 32'(r_valid), 32'd0);
        chk("async grant", 32'(r_gnt), 32'd0);
        chk("async data", r_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post rst valid", 32'(r_valid), 32'd0);
        chk("post rst hold", 32'(r_hold), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
